sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Pin-level SDR SDRAM responder: the device end of the bus driven by the team's SDRAM controllers.
- Decodes nCS/nRAS/nCAS/nWE commands, tracks per-bank open rows and the mode register, and serves reads/writes from on-chip block RAM.
- Used as a drop-in SDRAM substitute on boards without SDRAM and as a protocol-checking target in controller testbenches.

Parameters:
- MEM_ABITS, 14: word-address width of the backing RAM (2^14 x 16); the linear address {ba,row,col} is truncated to its low MEM_ABITS bits.
- COL_BITS, 8: column address width, taken from sd_a[COL_BITS-1:0].
- ROW_BITS, 12: row address width, taken from sd_a[ROW_BITS-1:0].

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- sd_cke  in  1  clock enable; 0 freezes all state.
- sd_ncs, sd_nras, sd_ncas, sd_nwe  in  1 each  command bits.
- sd_ba  in  2  bank address.
- sd_a  in  12  multiplexed address.
- sd_dqml, sd_dqmh  in  1 each  write byte masks (low/high lane).
- sd_dq_in  in  16  data from controller.
- sd_dq_out  out  16  read data.
- sd_dq_oe  out  1  read data valid / drive enable.
- mode_reg  out  12  current mode register.
- refresh_count  out  16  AUTO_REFRESH count, wraps.
- proto_err  out  1  one-cycle error pulse.
- err_code  out  3  code of the last error.

Behaviour:
- Reset values: mode_reg=12'h220 (single-write, CL=2, sequential, BL=1); all banks closed; read pipeline empty; sd_dq_oe=0; sd_dq_out=0; refresh_count=0; proto_err=0; err_code=0. Memory contents are not cleared.
- Reset mid-burst aborts the burst; sd_dq_oe=0 after the reset edge.
- sd_cke=0: inputs ignored, burst counters and read pipeline hold, outputs hold. sd_ncs=1 is INHIBIT; {nRAS,nCAS,nWE}=111 is NOP.
- LOAD_MODE (000): all banks must be closed, else err 1 and command ignored. CL field a[6:4] must be 2 or 3, else err 2 and CL/BL unchanged. BL a[2:0] 000/001/010/011 = 1/2/4/8; other values give err 2. a[9]=1 selects single-beat writes.
- ACTIVE (011): opens bank ba with row a. If the bank is already open: err 3, old row kept.
- READ (101) / WRITE (100): column = a[COL_BITS-1:0]; a[10] = auto-precharge. A closed target bank gives err 4 and the command is ignored.
  - Burst beats step the low log2(BL) column bits modulo BL (sequential wrap); upper column bits stay fixed.
- Write beats: beat 0 data and masks are sampled on the command edge, then one beat per following edge. sd_dqmh=1 masks [15:8]; sd_dqml=1 masks [7:0]. In single-write mode the burst is 1 beat.
- Read latency: for a READ sampled at edge T, beat k is driven with sd_dq_oe=1 from edge T+CL-1+k, valid for sampling at edge T+CL+k. sd_dq_oe falls after the last beat. Read DQM is ignored.
- Burst interruption:
  - A new READ/WRITE ends the current burst.
  - BURST_TERMINATE (110) ends it.
  - PRECHARGE of the burst's bank ends it.
  - A WRITE arriving while read beats are pending flushes them; sd_dq_oe=0 on the next edge.
- Auto-precharge closes the bank after the last beat, or at interruption.
- PRECHARGE (010): a[10]=1 closes all banks, else closes bank ba. Precharging an idle bank is legal.
- AUTO_REFRESH (001): any open bank gives err 5 and no count; otherwise refresh_count increments, wrapping 0xFFFF->0.
- Errors: proto_err pulses on the edge after the offending command; err_code holds until the next error.
- Memory is a single-port synchronous RAM, 1-cycle read. A write beat and a read issue never share a cycle, because a write flushes pending reads.

Test Plan:
- Init sequence (PRECHARGE a10=1, 2x AUTO_REFRESH, LOAD_MODE a=12'h220) -> mode_reg=12'h220, refresh_count=2, proto_err never asserted.
- ACTIVE ba=1 row=0x123; WRITE col=0x45 dq=0xBEEF dqmh=1; READ col=0x45 -> data 0x??EF with the high byte unchanged, valid exactly at edge T+2; repeat with CL=3 -> valid at T+3.
- LOAD_MODE BL=4 with a[9]=0; WRITE col=0x06 beats A,B,C,D; READ col=0x06 -> beats return in column order 6,7,4,5 with values A,B,C,D; sd_dq_oe high for exactly 4 cycles.
- READ with a10=1, then ACTIVE on the same bank 4 cycles later -> no error; READ on a closed bank -> proto_err pulse, err_code=4, sd_dq_oe stays 0.
- AUTO_REFRESH with bank 2 open -> err_code=5, refresh_count unchanged; LOAD_MODE with CL=1 -> err_code=2, mode_reg unchanged.
- Reset asserted mid BL=8 read -> sd_dq_oe=0 after the reset edge, all banks closed, and a following READ gives err 4.

Source files
------------

// File: rtl/sdram_responder.sv
// sdram_responder: device end of an SDR SDRAM bus backed by on-chip block RAM.
// Decodes SDRAM commands and tracks open rows per bank and the mode register.
// Serves read/write bursts (sequential wrap, CL 2/3) and flags protocol errors.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   sd_cke                     clock enable; low freezes all state and outputs
//   sd_ncs/nras/ncas/nwe       command bits
//   sd_ba, sd_a                bank and multiplexed row/column/mode address
//   sd_dqml, sd_dqmh           write byte masks (low/high lane)
//   sd_dq_in                   write data from the controller
//   sd_dq_out, sd_dq_oe        read data and its drive enable
//   mode_reg                   current mode register
//   refresh_count              AUTO_REFRESH counter (wraps)
//   proto_err, err_code        one-cycle error pulse and code of the last error
module sdram_responder #(
    parameter int unsigned MEM_ABITS = 14,
    parameter int unsigned COL_BITS  = 8,
    parameter int unsigned ROW_BITS  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_cke,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [1:0]  sd_ba,
    input  logic [11:0] sd_a,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    output logic [11:0] mode_reg,
    output logic [15:0] refresh_count,
    output logic        proto_err,
    output logic [2:0]  err_code
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e state_q, state_d;

    // Burst context captured at the READ/WRITE command
    logic [1:0]          bst_bank_q, bst_bank_d;
    logic [ROW_BITS-1:0] bst_row_q, bst_row_d;
    logic [COL_BITS-1:0] bst_col_q, bst_col_d;
    logic [2:0]          bst_k_q, bst_k_d;
    logic [3:0]          bst_len_q, bst_len_d;
    logic                bst_ap_q, bst_ap_d;

    logic [3:0]          open_q, open_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] row_d [4];
    logic [11:0]         mode_q, mode_d;
    logic [15:0]         ref_q, ref_d;
    logic                perr_q, perr_d;
    logic [2:0]          ecode_q, ecode_d;

    // Read pipeline: p1 = RAM data valid, p2 = extra stage used for CL=3
    logic        p1_q, p2_q, oe_q;
    logic [15:0] rdata_q, d2_q, dout_q;

    logic [15:0] mem [2**MEM_ABITS];

    logic                 ram_we, ram_re;
    logic [1:0]           ram_be;
    logic [MEM_ABITS-1:0] ram_addr;

    function automatic logic [MEM_ABITS-1:0] lin_addr(input logic [1:0]          ba,
                                                      input logic [ROW_BITS-1:0] row,
                                                      input logic [COL_BITS-1:0] col);
        return MEM_ABITS'({ba, row, col});
    endfunction

    // Low column bits advance modulo the burst length; upper bits stay fixed
    function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] start,
                                                     input logic [2:0]          k,
                                                     input logic [2:0]          mask);
        logic [2:0]          lo;
        logic [COL_BITS-1:0] m;
        lo = start[2:0] + k;
        m  = COL_BITS'(mask);
        return (start & ~m) | (COL_BITS'(lo) & m);
    endfunction

    // Command decode; cke low or nCS high makes every command disappear
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       is_lmr, is_ref, is_pre, is_act, is_wr, is_rd, is_bst;
    logic       rd_ok, wr_ok, rw_ok;
    logic [3:0] bl_len, new_len;
    logic [2:0] bst_mask;
    logic       cl3;
    logic       bst_busy, bst_stop, bst_cont, bst_last;

    always_comb begin
        cmd_valid = sd_cke & ~sd_ncs;
        cmd       = {sd_nras, sd_ncas, sd_nwe};
        is_lmr    = cmd_valid && (cmd == 3'b000);
        is_ref    = cmd_valid && (cmd == 3'b001);
        is_pre    = cmd_valid && (cmd == 3'b010);
        is_act    = cmd_valid && (cmd == 3'b011);
        is_wr     = cmd_valid && (cmd == 3'b100);
        is_rd     = cmd_valid && (cmd == 3'b101);
        is_bst    = cmd_valid && (cmd == 3'b110);
        rd_ok     = is_rd && open_q[sd_ba];
        wr_ok     = is_wr && open_q[sd_ba];
        rw_ok     = rd_ok | wr_ok;
        bl_len    = 4'd1 << mode_q[1:0];
        new_len   = (wr_ok && mode_q[9]) ? 4'd1 : bl_len;
        bst_mask  = bst_len_q[2:0] - 3'd1;
        cl3       = (mode_q[6:4] == 3'd3);
        bst_busy  = (state_q != StIdle);
        bst_stop  = bst_busy && (rw_ok || is_bst ||
                                 (is_pre && (sd_a[10] || (sd_ba == bst_bank_q))));
        bst_cont  = bst_busy && !bst_stop && sd_cke;
        bst_last  = bst_cont && ({1'b0, bst_k_q} == (bst_len_q - 4'd1));
    end

    // Burst FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bst_bank_q <= '0;
            bst_row_q  <= '0;
            bst_col_q  <= '0;
            bst_k_q    <= '0;
            bst_len_q  <= 4'd1;
            bst_ap_q   <= 1'b0;
        end else if (sd_cke) begin
            state_q    <= state_d;
            bst_bank_q <= bst_bank_d;
            bst_row_q  <= bst_row_d;
            bst_col_q  <= bst_col_d;
            bst_k_q    <= bst_k_d;
            bst_len_q  <= bst_len_d;
            bst_ap_q   <= bst_ap_d;
        end
    end

    // Burst FSM: next state
    always_comb begin
        state_d    = state_q;
        bst_bank_d = bst_bank_q;
        bst_row_d  = bst_row_q;
        bst_col_d  = bst_col_q;
        bst_k_d    = bst_k_q;
        bst_len_d  = bst_len_q;
        bst_ap_d   = bst_ap_q;
        if (rw_ok) begin
            // Beat 0 is served on the command edge itself
            bst_bank_d = sd_ba;
            bst_row_d  = row_q[sd_ba];
            bst_col_d  = sd_a[COL_BITS-1:0];
            bst_k_d    = 3'd1;
            bst_len_d  = new_len;
            bst_ap_d   = sd_a[10];
            if (new_len == 4'd1) begin
                state_d = StIdle;
            end else begin
                state_d = rd_ok ? StRead : StWrite;
            end
        end else if (bst_stop || bst_last) begin
            state_d = StIdle;
        end else if (bst_cont) begin
            bst_k_d = bst_k_q + 3'd1;
        end
    end

    // Burst FSM: RAM port control
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_be   = ~{sd_dqmh, sd_dqml};
        ram_addr = '0;
        if (rw_ok) begin
            ram_we   = wr_ok;
            ram_re   = rd_ok;
            ram_addr = lin_addr(sd_ba, row_q[sd_ba], sd_a[COL_BITS-1:0]);
        end else if (bst_cont) begin
            ram_we   = (state_q == StWrite);
            ram_re   = (state_q == StRead);
            ram_addr = lin_addr(bst_bank_q, bst_row_q, beat_col(bst_col_q, bst_k_q, bst_mask));
        end
    end

    // Bank, mode, refresh and error bookkeeping
    always_comb begin
        logic       err_set;
        logic [2:0] err_val;
        open_d  = open_q;
        row_d   = row_q;
        mode_d  = mode_q;
        ref_d   = ref_q;
        err_set = 1'b0;
        err_val = 3'd0;

        // Auto-precharge closes the burst bank after its last beat or when cut short
        if ((bst_stop || bst_last) && bst_ap_q) begin
            open_d[bst_bank_q] = 1'b0;
        end
        if (rw_ok && sd_a[10] && (new_len == 4'd1)) begin
            open_d[sd_ba] = 1'b0;
        end

        if (is_pre) begin
            if (sd_a[10]) begin
                open_d = '0;
            end else begin
                open_d[sd_ba] = 1'b0;
            end
        end

        if (is_act) begin
            if (open_q[sd_ba]) begin
                err_set = 1'b1;
                err_val = 3'd3;
            end else begin
                open_d[sd_ba] = 1'b1;
                row_d[sd_ba]  = sd_a[ROW_BITS-1:0];
            end
        end

        if ((is_rd || is_wr) && !open_q[sd_ba]) begin
            err_set = 1'b1;
            err_val = 3'd4;
        end

        if (is_lmr) begin
            if (|open_q) begin
                err_set = 1'b1;
                err_val = 3'd1;
            end else if ((sd_a[6:4] != 3'd2 && sd_a[6:4] != 3'd3) || sd_a[2]) begin
                err_set = 1'b1;
                err_val = 3'd2;
            end else begin
                mode_d = sd_a;
            end
        end

        if (is_ref) begin
            if (|open_q) begin
                err_set = 1'b1;
                err_val = 3'd5;
            end else begin
                ref_d = ref_q + 16'd1;
            end
        end

        perr_d  = err_set;
        ecode_d = err_set ? err_val : ecode_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            open_q  <= '0;
            row_q   <= '{default: '0};
            mode_q  <= 12'h220;
            ref_q   <= '0;
            perr_q  <= 1'b0;
            ecode_q <= '0;
        end else if (sd_cke) begin
            open_q  <= open_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            ref_q   <= ref_d;
            perr_q  <= perr_d;
            ecode_q <= ecode_d;
        end
    end

    // Backing RAM: single port, one-cycle read, contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            if (ram_be[0]) mem[ram_addr][7:0]  <= sd_dq_in[7:0];
            if (ram_be[1]) mem[ram_addr][15:8] <= sd_dq_in[15:8];
        end
        if (ram_re) begin
            rdata_q <= mem[ram_addr];
        end
    end

    // Read output pipeline; an accepted WRITE drops any beats still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q   <= 1'b0;
            p2_q   <= 1'b0;
            d2_q   <= '0;
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else if (sd_cke) begin
            if (wr_ok) begin
                p1_q <= 1'b0;
                p2_q <= 1'b0;
                oe_q <= 1'b0;
            end else begin
                p1_q <= ram_re;
                p2_q <= p1_q;
                d2_q <= rdata_q;
                if (cl3) begin
                    oe_q <= p2_q;
                    if (p2_q) dout_q <= d2_q;
                end else begin
                    oe_q <= p1_q;
                    if (p1_q) dout_q <= rdata_q;
                end
            end
        end
    end

    assign sd_dq_out     = dout_q;
    assign sd_dq_oe      = oe_q;
    assign mode_reg      = mode_q;
    assign refresh_count = ref_q;
    assign proto_err     = perr_q;
    assign err_code      = ecode_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Testbench for sdram_responder: drives command sequences and checks reads via a
// scoreboard of expected (edge, data) beats, plus direct checks of status outputs.
module tb_sdram_responder;

    localparam logic [3:0] CNop = 4'b0111;
    localparam logic [3:0] CLmr = 4'b0000;
    localparam logic [3:0] CRef = 4'b0001;
    localparam logic [3:0] CPre = 4'b0010;
    localparam logic [3:0] CAct = 4'b0011;
    localparam logic [3:0] CWr  = 4'b0100;
    localparam logic [3:0] CRd  = 4'b0101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sd_cke = 1'b1;
    logic        sd_ncs = 1'b0;
    logic        sd_nras = 1'b1;
    logic        sd_ncas = 1'b1;
    logic        sd_nwe = 1'b1;
    logic [1:0]  sd_ba = '0;
    logic [11:0] sd_a = '0;
    logic        sd_dqml = 1'b0;
    logic        sd_dqmh = 1'b0;
    logic [15:0] sd_dq_in = '0;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;
    logic [11:0] mode_reg;
    logic [15:0] refresh_count;
    logic        proto_err;
    logic [2:0]  err_code;

    sdram_responder dut (
        .clk           (clk),
        .reset         (reset),
        .sd_cke        (sd_cke),
        .sd_ncs        (sd_ncs),
        .sd_nras       (sd_nras),
        .sd_ncas       (sd_ncas),
        .sd_nwe        (sd_nwe),
        .sd_ba         (sd_ba),
        .sd_a          (sd_a),
        .sd_dqml       (sd_dqml),
        .sd_dqmh       (sd_dqmh),
        .sd_dq_in      (sd_dq_in),
        .sd_dq_out     (sd_dq_out),
        .sd_dq_oe      (sd_dq_oe),
        .mode_reg      (mode_reg),
        .refresh_count (refresh_count),
        .proto_err     (proto_err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int err_pulses = 0;
    bit mon_en = 1'b1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_beat(input int c, input logic [15:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Drive one command for one edge; returns #1 after that edge
    task automatic cmd(input logic [3:0] c, input logic [1:0] ba = 2'd0,
                       input logic [11:0] a = 12'h000, input logic [15:0] dq = 16'h0000,
                       input logic dqmh = 1'b0, input logic dqml = 1'b0);
        sd_ncs   = c[3];
        sd_nras  = c[2];
        sd_ncas  = c[1];
        sd_nwe   = c[0];
        sd_ba    = ba;
        sd_a     = a;
        sd_dq_in = dq;
        sd_dqmh  = dqmh;
        sd_dqml  = dqml;
        @(posedge clk);
        #1;
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = CNop;
        sd_dqmh = 1'b0;
        sd_dqml = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        cmd(CNop, 2'd0, 12'h000, d);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cmd(CNop);
    endtask

    // Monitor: every driven read beat must match the head of the scoreboard
    always @(posedge clk) begin
        #2;
        if (proto_err) err_pulses++;
        if (sd_dq_oe && mon_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_oe", 32'(sd_dq_oe), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_data", 32'(sd_dq_out), 32'(mon_e.data));
                check("rd_edge", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    int t;
    int p0;

    initial begin
        nops(3);
        reset = 1'b0;
        check("rst_mode", 32'(mode_reg), 32'h220);
        check("rst_refcnt", 32'(refresh_count), 32'd0);
        check("rst_oe", 32'(sd_dq_oe), 32'd0);
        check("rst_dq_out", 32'(sd_dq_out), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        check("rst_ecode", 32'(err_code), 32'd0);

        // Init sequence
        cmd(CPre, 2'd0, 12'h400);
        cmd(CRef);
        cmd(CRef);
        cmd(CLmr, 2'd0, 12'h220);
        nops(1);
        check("init_mode", 32'(mode_reg), 32'h220);
        check("init_refcnt", 32'(refresh_count), 32'd2);
        check("init_no_err", 32'(err_pulses), 32'd0);

        // Byte-masked write, CL=2 then CL=3 read
        cmd(CAct, 2'd1, 12'h123);
        cmd(CWr, 2'd1, 12'h045, 16'h1234);
        cmd(CWr, 2'd1, 12'h045, 16'hBEEF, 1'b1, 1'b0);
        cmd(CRd, 2'd1, 12'h045);
        expect_beat(cyc + 1, 16'h12EF);
        nops(4);
        cmd(CPre, 2'd0, 12'h400);
        cmd(CLmr, 2'd0, 12'h230);
        cmd(CAct, 2'd1, 12'h123);
        cmd(CRd, 2'd1, 12'h045);
        expect_beat(cyc + 2, 16'h12EF);
        nops(5);

        // BL=4 sequential wrap
        cmd(CPre, 2'd0, 12'h400);
        cmd(CLmr, 2'd0, 12'h022);
        cmd(CAct, 2'd1, 12'h123);
        cmd(CWr, 2'd1, 12'h006, 16'h1111);
        beat(16'h2222);
        beat(16'h3333);
        beat(16'h4444);
        cmd(CRd, 2'd1, 12'h006);
        t = cyc;
        expect_beat(t + 1, 16'h1111);
        expect_beat(t + 2, 16'h2222);
        expect_beat(t + 3, 16'h3333);
        expect_beat(t + 4, 16'h4444);
        nops(6);
        cmd(CRd, 2'd1, 12'h004);
        t = cyc;
        expect_beat(t + 1, 16'h3333);
        expect_beat(t + 2, 16'h4444);
        expect_beat(t + 3, 16'h1111);
        expect_beat(t + 4, 16'h2222);
        nops(6);

        // Auto-precharge read, then re-activate 4 cycles later
        p0 = err_pulses;
        cmd(CRd, 2'd1, 12'h404);
        t = cyc;
        expect_beat(t + 1, 16'h3333);
        expect_beat(t + 2, 16'h4444);
        expect_beat(t + 3, 16'h1111);
        expect_beat(t + 4, 16'h2222);
        nops(3);
        cmd(CAct, 2'd1, 12'h123);
        nops(4);
        check("ap_no_err", 32'(err_pulses), 32'(p0));
        check("ap_ecode", 32'(err_code), 32'd0);

        // A WRITE flushes pending read beats
        cmd(CRd, 2'd1, 12'h006);
        expect_beat(cyc + 1, 16'h1111);
        nops(1);
        cmd(CWr, 2'd1, 12'h010, 16'h5555);
        check("flush_oe", 32'(sd_dq_oe), 32'd0);
        beat(16'h6666);
        beat(16'h7777);
        beat(16'h8888);
        nops(4);

        // READ on a closed bank
        cmd(CRd, 2'd0, 12'h000);
        check("closed_perr", 32'(proto_err), 32'd1);
        check("closed_ecode", 32'(err_code), 32'd4);
        nops(1);
        check("closed_oe", 32'(sd_dq_oe), 32'd0);
        check("perr_pulse_end", 32'(proto_err), 32'd0);
        nops(3);

        // Refresh with a bank open; bad CAS latency
        cmd(CAct, 2'd2, 12'h007);
        cmd(CRef);
        check("ref_open_ecode", 32'(err_code), 32'd5);
        check("ref_open_cnt", 32'(refresh_count), 32'd2);
        cmd(CPre, 2'd0, 12'h400);
        cmd(CLmr, 2'd0, 12'h012);
        check("lmr_cl1_ecode", 32'(err_code), 32'd2);
        check("lmr_cl1_mode", 32'(mode_reg), 32'h022);

        // cke low ignores commands
        sd_cke = 1'b0;
        cmd(CRef);
        sd_cke = 1'b1;
        nops(1);
        check("cke_refcnt", 32'(refresh_count), 32'd2);

        // Reset mid BL=8 read
        cmd(CLmr, 2'd0, 12'h023);
        cmd(CAct, 2'd0, 12'h005);
        mon_en = 1'b0;
        cmd(CRd, 2'd0, 12'h000);
        nops(2);
        check("bl8_oe_active", 32'(sd_dq_oe), 32'd1);
        reset = 1'b1;
        nops(1);
        reset = 1'b0;
        check("rstmid_oe", 32'(sd_dq_oe), 32'd0);
        check("rstmid_mode", 32'(mode_reg), 32'h220);
        check("rstmid_refcnt", 32'(refresh_count), 32'd0);
        nops(1);
        check("rstmid_oe2", 32'(sd_dq_oe), 32'd0);
        mon_en = 1'b1;
        cmd(CRd, 2'd0, 12'h000);
        check("rstmid_closed_perr", 32'(proto_err), 32'd1);
        check("rstmid_closed_ecode", 32'(err_code), 32'd4);
        nops(4);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
